sap_display_driver: RTL and testbench

Downstream consumer of the 8-bit accumulator output register. Captures each value written to the output register, converts it to decimal with a sequential double-dabble engine, and drives a four-digit, common-anode, multiplexed seven-segment display. A one-deep pending slot absorbs writes that arrive during a conversion.

---
 rtl/sap_display_driver_if.sv | 12 +
 rtl/sap_display_driver.sv | 199 +++++++++++++++++++
 tb/tb_sap_display_driver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sap_display_driver_if.sv
// Bus between the output register and the display driver: write strobe/data in,
// multiplexed seven-segment drive and busy flag out.
interface sap_display_driver_if;
    logic [7:0] data_in;
    logic       load;
    logic [7:0] seg;
    logic [3:0] dig_sel;
    logic       busy;

    modport master (output data_in, load, input  seg, dig_sel, busy);
    modport slave  (input  data_in, load, output seg, dig_sel, busy);
endinterface

// File: rtl/sap_display_driver.sv
// Output-register display driver: double-dabble binary-to-BCD conversion with a
// one-deep pending slot, feeding a 4-digit multiplexed common-anode display.
// Optional macro SAP_DISPLAY_SIGNED_EN: treat data_in as two's complement and show a sign digit.
module sap_display_driver #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic                 clk,
    input logic                 clr,
    sap_display_driver_if.slave bus
);
    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] SCAN_TC = PW'(SCAN_DIV - 1);
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    bin_q, bin_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [2:0]    iter_q, iter_d;
    logic [7:0]    pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [3:0]    hund_q, hund_d, tens_q, tens_d, unit_q, unit_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          busy_q, busy_d;
    logic          cap_c;
    logic [7:0]    cap_raw_c;
    logic [11:0]   adj_c;
    logic [7:0]    sign_seg_c;
`ifdef SAP_DISPLAY_SIGNED_EN
    logic          cneg_q, cneg_d, dneg_q, dneg_d;
`endif

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction on every BCD nibble ahead of the shift
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            adj_c[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                          : bcd_q[4*k +: 4];
        end
    end

    // Conversion FSM, pending slot and display-register update
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        unit_d     = unit_q;
        cap_c      = 1'b0;
        cap_raw_c  = bus.data_in;
`ifdef SAP_DISPLAY_SIGNED_EN
        cneg_d     = cneg_q;
        dneg_d     = dneg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    cap_c      = 1'b1;
                    cap_raw_c  = pend_q;
                    pend_vld_d = 1'b0;
                end else if (bus.load) begin
                    cap_c = 1'b1;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {adj_c[10:0], bin_q, 1'b0};
                iter_d         = iter_q + 3'd1;
                if (iter_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                hund_d = bcd_q[11:8];
                tens_d = bcd_q[7:4];
                unit_d = bcd_q[3:0];
`ifdef SAP_DISPLAY_SIGNED_EN
                dneg_d = cneg_q;
`endif
                if (pend_vld_q) begin
                    cap_c      = 1'b1;
                    cap_raw_c  = pend_q;
                    pend_vld_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load that cannot start immediately lands in the slot; last write wins
        if (bus.load && ((state_q != IDLE) || pend_vld_q)) begin
            pend_d     = bus.data_in;
            pend_vld_d = 1'b1;
        end

        if (cap_c) begin
            state_d = CONV;
            bcd_d   = 12'd0;
            iter_d  = 3'd0;
`ifdef SAP_DISPLAY_SIGNED_EN
            bin_d   = cap_raw_c[7] ? 8'(~cap_raw_c + 8'd1) : cap_raw_c;
            cneg_d  = cap_raw_c[7];
`else
            bin_d   = cap_raw_c;
`endif
        end
    end

    // Digit scan and segment lookup with leading-zero blanking
    always_comb begin
`ifdef SAP_DISPLAY_SIGNED_EN
        sign_seg_c = dneg_q ? SEG_MINUS : SEG_BLANK;
`else
        sign_seg_c = SEG_BLANK;
`endif
        presc_d = (presc_q == SCAN_TC) ? '0 : presc_q + PW'(1);
        idx_d   = (presc_q == SCAN_TC) ? idx_q + 2'd1 : idx_q;
        dig_d   = ~(4'b0001 << idx_q);
        unique case (idx_q)
            2'd0:    seg_d = seg7(unit_q);
            2'd1:    seg_d = ((hund_q == 4'd0) && (tens_q == 4'd0)) ? SEG_BLANK : seg7(tens_q);
            2'd2:    seg_d = (hund_q == 4'd0) ? SEG_BLANK : seg7(hund_q);
            default: seg_d = sign_seg_c;
        endcase
        busy_d = (state_d != IDLE) | pend_vld_d;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            bin_q      <= 8'd0;
            bcd_q      <= 12'd0;
            iter_q     <= 3'd0;
            pend_q     <= 8'd0;
            pend_vld_q <= 1'b0;
            hund_q     <= 4'd0;
            tens_q     <= 4'd0;
            unit_q     <= 4'd0;
            presc_q    <= '0;
            idx_q      <= 2'd0;
            seg_q      <= SEG_BLANK;
            dig_q      <= 4'b1111;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            unit_q     <= unit_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SAP_DISPLAY_SIGNED_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cneg_q <= 1'b0;
            dneg_q <= 1'b0;
        end else begin
            cneg_q <= cneg_d;
            dneg_q <= dneg_d;
        end
    end
`endif

    assign bus.seg     = seg_q;
    assign bus.dig_sel = dig_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_sap_display_driver.sv
// Bench for sap_display_driver: directed scenarios plus random loads, checked
// each cycle against a decimal-value model of the display and conversion timing.
module tb_sap_display_driver;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    sap_display_driver_if bus ();
    sap_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (.clk(clk), .clr(clr), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Model: cycles left in the running conversion, its decimal value, pending slot, shown value
    int   m_left, m_cval, m_pend_raw, m_disp, m_presc, m_idx;
    bit   m_cneg, m_pend_v, m_neg;
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_busy;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_glyph(input int i, input int v, input bit n);
        case (i)
            0:       return lut[v % 10];
            1:       return (v < 10) ? 8'hFF : lut[(v / 10) % 10];
            2:       return (v < 100) ? 8'hFF : lut[v / 100];
            default: return n ? 8'hBF : 8'hFF;
        endcase
    endfunction

    function automatic void model_reset();
        m_left = 0; m_cval = 0; m_cneg = 0; m_pend_v = 0; m_pend_raw = 0;
        m_disp = 0; m_neg = 0; m_presc = 0; m_idx = 0;
        e_seg = 8'hFF; e_dig = 4'hF; e_busy = 1'b0;
    endfunction

    function automatic void start(input int raw);
        m_left = 9;
`ifdef SAP_DISPLAY_SIGNED_EN
        m_cneg = (raw >= 128);
        m_cval = (raw >= 128) ? 256 - raw : raw;
`else
        m_cneg = 0;
        m_cval = raw;
`endif
    endfunction

    function automatic void model_edge(input bit ld, input int d);
        bit pre_conv, pre_pend;
        e_seg = exp_glyph(m_idx, m_disp, m_neg);
        e_dig = ~(4'b0001 << m_idx);
        if (m_presc == SCAN_DIV - 1) begin
            m_presc = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_presc++;
        end
        pre_conv = (m_left > 0);
        pre_pend = m_pend_v;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_disp = m_cval;
                m_neg = m_cneg;
                if (m_pend_v) begin
                    start(m_pend_raw);
                    m_pend_v = 0;
                end
            end
        end else if (m_pend_v) begin
            start(m_pend_raw);
            m_pend_v = 0;
        end else if (ld) begin
            start(d);
        end
        if (ld && (pre_conv || pre_pend)) begin
            m_pend_raw = d;
            m_pend_v = 1;
        end
        e_busy = (m_left > 0) || m_pend_v;
    endfunction

    task automatic cycle(input bit ld, input logic [7:0] d);
        bus.load = ld;
        bus.data_in = d;
        @(posedge clk);
        model_edge(ld, int'(d));
        #1;
        chk("seg", bus.seg, e_seg);
        chk("dig_sel", {4'h0, bus.dig_sel}, {4'h0, e_dig});
        chk("busy", {7'h0, bus.busy}, {7'h0, e_busy});
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    // Walk one full scan and compare each digit against fixed glyphs
    task automatic scan_check(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0);
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            cycle(1'b0, 8'h00);
            case (bus.dig_sel)
                4'b1110: chk({tag, "_units"}, bus.seg, s0);
                4'b1101: chk({tag, "_tens"},  bus.seg, s1);
                4'b1011: chk({tag, "_hund"},  bus.seg, s2);
                4'b0111: chk({tag, "_sign"},  bus.seg, s3);
                default: chk({tag, "_digsel_onehot"}, {4'h0, bus.dig_sel}, 8'h0E);
            endcase
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_seg"}, bus.seg, 8'hFF);
        chk({tag, "_dig"}, {4'h0, bus.dig_sel}, 8'h0F);
        chk({tag, "_busy"}, {7'h0, bus.busy}, 8'h00);
    endtask

    logic [7:0] rd;
    logic [7:0] picks [8] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd127, 8'd128, 8'd255};

    initial begin
        clr = 1'b0;
        bus.load = 1'b0;
        bus.data_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_check("reset");
        clr = 1'b1;

        // Idle scan: units shows 0, everything else blank
        idx_scan: begin
            idle(20);
            scan_check("idle", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        end

        cycle(1'b1, 8'd255);
        idle(12);
        scan_check("v255", 8'hFF, 8'hA4, 8'h92, 8'h92);

        cycle(1'b1, 8'd17);
        idle(2);
        cycle(1'b1, 8'd42);
        idle(24);
        scan_check("v42", 8'hFF, 8'hFF, 8'h99, 8'hA4);

        cycle(1'b1, 8'd5);
        idle(2);
        cycle(1'b1, 8'd9);
        idle(2);
        cycle(1'b1, 8'd200);
        idle(24);
        scan_check("v200", 8'hFF, 8'hA4, 8'hC0, 8'hC0);

        cycle(1'b1, 8'hF6);
        idle(12);
`ifdef SAP_DISPLAY_SIGNED_EN
        scan_check("vF6", 8'hBF, 8'hFF, 8'hF9, 8'hC0);
`else
        scan_check("vF6", 8'hFF, 8'hA4, 8'h99, 8'h82);
`endif

        // Abort mid-conversion with a pending write queued
        cycle(1'b1, 8'd99);
        cycle(1'b1, 8'd77);
        idle(2);
        clr = 1'b0;
        #1;
        model_reset();
        reset_check("abort");
        repeat (2) @(posedge clk);
        #1;
        reset_check("abort_hold");
        clr = 1'b1;
        idle(20);
        scan_check("post_abort", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

        // Random traffic, biased toward digit-boundary values
        for (int i = 0; i < 1500; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 7)] : 8'($urandom);
            cycle($urandom_range(0, 5) == 0, rd);
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
